// File: rtl/pipe_reg_bank.sv
// pipe_reg_bank: IF/ID, ID/EX and EX/MEM pipeline registers with per-stage flush; define PIPE_STALL_EN to add the i_stall load-use input
module pipe_reg_bank #(
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter logic [6:0]  NOP_OPCODE = 7'h13
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef PIPE_STALL_EN
  input  logic        i_stall,
`endif
  input  logic        i_flush_if_id,
  input  logic        i_flush_id_ex,
  input  logic [31:0] i_if_id_pc,
  input  logic [31:0] i_if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  input  logic [31:0] i_id_ex_pc,
  input  logic [31:0] i_id_ex_rs_1,
  input  logic [31:0] i_id_ex_rs_2,
  input  logic [4:0]  i_id_ex_rd_num,
  input  logic [6:0]  i_id_ex_opcode,
  input  logic [6:0]  i_id_ex_func_7,
  input  logic [2:0]  i_id_ex_func_3,
  input  logic [11:0] i_id_ex_imm_12_i,
  input  logic [11:0] i_id_ex_imm_12_b,
  input  logic [11:0] i_id_ex_imm_12_s,
  input  logic [19:0] i_id_ex_imm_20,
  input  logic [19:0] i_id_ex_imm_20_i,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs_1,
  output logic [31:0] id_ex_rs_2,
  output logic [4:0]  id_ex_rd_num,
  output logic [6:0]  id_ex_opcode,
  output logic [6:0]  id_ex_func_7,
  output logic [2:0]  id_ex_func_3,
  output logic [11:0] id_ex_imm_12_i,
  output logic [11:0] id_ex_imm_12_b,
  output logic [11:0] id_ex_imm_12_s,
  output logic [19:0] id_ex_imm_20,
  output logic [19:0] id_ex_imm_20_i,
  input  logic [31:0] i_ex_mem_rs_2,
  input  logic [31:0] i_ex_mem_alu_out,
  input  logic [4:0]  i_ex_mem_rd_num,
  input  logic [6:0]  i_ex_mem_opcode,
  input  logic [2:0]  i_ex_mem_func_3,
  input  logic        i_ex_mem_op_type,
  output logic [31:0] ex_mem_rs_2,
  output logic [31:0] ex_mem_alu_out,
  output logic [4:0]  ex_mem_rd_num,
  output logic [6:0]  ex_mem_opcode,
  output logic [2:0]  ex_mem_func_3,
  output logic        ex_mem_op_type
);
  logic stall;
  logic bubble;
`ifdef PIPE_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif
  assign bubble = i_flush_id_ex | stall;
  // flush beats stall: a taken branch must squash the held instruction
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      if_id_pc   <= '0;
      if_id_inst <= NOP_INST;
    end else if (i_flush_if_id) begin
      if_id_pc   <= i_if_id_pc;
      if_id_inst <= NOP_INST;
    end else if (!stall) begin
      if_id_pc   <= i_if_id_pc;
      if_id_inst <= i_if_id_inst;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst || bubble) begin
      id_ex_pc       <= '0;
      id_ex_rs_1     <= '0;
      id_ex_rs_2     <= '0;
      id_ex_rd_num   <= '0;
      id_ex_opcode   <= NOP_OPCODE;
      id_ex_func_7   <= '0;
      id_ex_func_3   <= '0;
      id_ex_imm_12_i <= '0;
      id_ex_imm_12_b <= '0;
      id_ex_imm_12_s <= '0;
      id_ex_imm_20   <= '0;
      id_ex_imm_20_i <= '0;
    end else begin
      id_ex_pc       <= i_id_ex_pc;
      id_ex_rs_1     <= i_id_ex_rs_1;
      id_ex_rs_2     <= i_id_ex_rs_2;
      id_ex_rd_num   <= i_id_ex_rd_num;
      id_ex_opcode   <= i_id_ex_opcode;
      id_ex_func_7   <= i_id_ex_func_7;
      id_ex_func_3   <= i_id_ex_func_3;
      id_ex_imm_12_i <= i_id_ex_imm_12_i;
      id_ex_imm_12_b <= i_id_ex_imm_12_b;
      id_ex_imm_12_s <= i_id_ex_imm_12_s;
      id_ex_imm_20   <= i_id_ex_imm_20;
      id_ex_imm_20_i <= i_id_ex_imm_20_i;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ex_mem_rs_2    <= '0;
      ex_mem_alu_out <= '0;
      ex_mem_rd_num  <= '0;
      ex_mem_opcode  <= NOP_OPCODE;
      ex_mem_func_3  <= '0;
      ex_mem_op_type <= 1'b0;
    end else begin
      ex_mem_rs_2    <= i_ex_mem_rs_2;
      ex_mem_alu_out <= i_ex_mem_alu_out;
      ex_mem_rd_num  <= i_ex_mem_rd_num;
      ex_mem_opcode  <= i_ex_mem_opcode;
      ex_mem_func_3  <= i_ex_mem_func_3;
      ex_mem_op_type <= i_ex_mem_op_type;
    end
  end
endmodule

// File: tb/tb_pipe_reg_bank.sv
// tb_pipe_reg_bank: directed self-checking bench for pipe_reg_bank
module tb_pipe_reg_bank;
  logic        i_clk, i_rst, i_flush_if_id, i_flush_id_ex;
`ifdef PIPE_STALL_EN
  logic        i_stall;
`endif
  logic [31:0] i_if_id_pc, i_if_id_inst, if_id_pc, if_id_inst;
  logic [31:0] i_id_ex_pc, i_id_ex_rs_1, i_id_ex_rs_2;
  logic [4:0]  i_id_ex_rd_num;
  logic [6:0]  i_id_ex_opcode, i_id_ex_func_7;
  logic [2:0]  i_id_ex_func_3;
  logic [11:0] i_id_ex_imm_12_i, i_id_ex_imm_12_b, i_id_ex_imm_12_s;
  logic [19:0] i_id_ex_imm_20, i_id_ex_imm_20_i;
  logic [31:0] id_ex_pc, id_ex_rs_1, id_ex_rs_2;
  logic [4:0]  id_ex_rd_num;
  logic [6:0]  id_ex_opcode, id_ex_func_7;
  logic [2:0]  id_ex_func_3;
  logic [11:0] id_ex_imm_12_i, id_ex_imm_12_b, id_ex_imm_12_s;
  logic [19:0] id_ex_imm_20, id_ex_imm_20_i;
  logic [31:0] i_ex_mem_rs_2, i_ex_mem_alu_out, ex_mem_rs_2, ex_mem_alu_out;
  logic [4:0]  i_ex_mem_rd_num, ex_mem_rd_num;
  logic [6:0]  i_ex_mem_opcode, ex_mem_opcode;
  logic [2:0]  i_ex_mem_func_3, ex_mem_func_3;
  logic        i_ex_mem_op_type, ex_mem_op_type;
  int checks = 0;
  int failures = 0;
  pipe_reg_bank dut (
    .i_clk(i_clk), .i_rst(i_rst),
`ifdef PIPE_STALL_EN
    .i_stall(i_stall),
`endif
    .i_flush_if_id(i_flush_if_id), .i_flush_id_ex(i_flush_id_ex),
    .i_if_id_pc(i_if_id_pc), .i_if_id_inst(i_if_id_inst),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
    .i_id_ex_pc(i_id_ex_pc), .i_id_ex_rs_1(i_id_ex_rs_1), .i_id_ex_rs_2(i_id_ex_rs_2),
    .i_id_ex_rd_num(i_id_ex_rd_num), .i_id_ex_opcode(i_id_ex_opcode),
    .i_id_ex_func_7(i_id_ex_func_7), .i_id_ex_func_3(i_id_ex_func_3),
    .i_id_ex_imm_12_i(i_id_ex_imm_12_i), .i_id_ex_imm_12_b(i_id_ex_imm_12_b),
    .i_id_ex_imm_12_s(i_id_ex_imm_12_s), .i_id_ex_imm_20(i_id_ex_imm_20),
    .i_id_ex_imm_20_i(i_id_ex_imm_20_i),
    .id_ex_pc(id_ex_pc), .id_ex_rs_1(id_ex_rs_1), .id_ex_rs_2(id_ex_rs_2),
    .id_ex_rd_num(id_ex_rd_num), .id_ex_opcode(id_ex_opcode),
    .id_ex_func_7(id_ex_func_7), .id_ex_func_3(id_ex_func_3),
    .id_ex_imm_12_i(id_ex_imm_12_i), .id_ex_imm_12_b(id_ex_imm_12_b),
    .id_ex_imm_12_s(id_ex_imm_12_s), .id_ex_imm_20(id_ex_imm_20),
    .id_ex_imm_20_i(id_ex_imm_20_i),
    .i_ex_mem_rs_2(i_ex_mem_rs_2), .i_ex_mem_alu_out(i_ex_mem_alu_out),
    .i_ex_mem_rd_num(i_ex_mem_rd_num), .i_ex_mem_opcode(i_ex_mem_opcode),
    .i_ex_mem_func_3(i_ex_mem_func_3), .i_ex_mem_op_type(i_ex_mem_op_type),
    .ex_mem_rs_2(ex_mem_rs_2), .ex_mem_alu_out(ex_mem_alu_out),
    .ex_mem_rd_num(ex_mem_rd_num), .ex_mem_opcode(ex_mem_opcode),
    .ex_mem_func_3(ex_mem_func_3), .ex_mem_op_type(ex_mem_op_type)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic drive_all;
    i_if_id_pc = 32'h4; i_if_id_inst = 32'h0050_0093;
    i_id_ex_pc = 32'h100; i_id_ex_rs_1 = 32'h1111_1111; i_id_ex_rs_2 = 32'h2222_2222;
    i_id_ex_rd_num = 5'd7; i_id_ex_opcode = 7'h33; i_id_ex_func_7 = 7'h20; i_id_ex_func_3 = 3'h5;
    i_id_ex_imm_12_i = 12'h123; i_id_ex_imm_12_b = 12'h456; i_id_ex_imm_12_s = 12'h789;
    i_id_ex_imm_20 = 20'hABCDE; i_id_ex_imm_20_i = 20'h12345;
    i_ex_mem_rs_2 = 32'hCAFE_F00D; i_ex_mem_alu_out = 32'hDEAD_BEEF; i_ex_mem_rd_num = 5'd9;
    i_ex_mem_opcode = 7'h23; i_ex_mem_func_3 = 3'h2; i_ex_mem_op_type = 1'b1;
  endtask
  task automatic test_reset;
    drive_all();
    tick();
    #2;
    i_rst = 1'b0;
    #1;
    checks++; if (if_id_inst !== 32'h13) begin failures++; $display("FAIL reset_if_id_inst got=%h exp=%h", if_id_inst, 32'h13); end
    checks++; if (if_id_pc !== 32'h0) begin failures++; $display("FAIL reset_if_id_pc got=%h exp=0", if_id_pc); end
    checks++; if (id_ex_opcode !== 7'h13) begin failures++; $display("FAIL reset_id_ex_opcode got=%h exp=13", id_ex_opcode); end
    checks++; if ({id_ex_pc, id_ex_rs_1, id_ex_rs_2, id_ex_rd_num, id_ex_func_7, id_ex_func_3} !== '0) begin failures++; $display("FAIL reset_id_ex_fields got nonzero pc=%h rs1=%h rd=%h", id_ex_pc, id_ex_rs_1, id_ex_rd_num); end
    checks++; if ({id_ex_imm_12_i, id_ex_imm_12_b, id_ex_imm_12_s, id_ex_imm_20, id_ex_imm_20_i} !== '0) begin failures++; $display("FAIL reset_id_ex_imm got nonzero imm20=%h exp=0", id_ex_imm_20); end
    checks++; if (ex_mem_opcode !== 7'h13 || ex_mem_op_type !== 1'b0) begin failures++; $display("FAIL reset_ex_mem_ctl got op=%h type=%b exp op=13 type=0", ex_mem_opcode, ex_mem_op_type); end
    checks++; if ({ex_mem_rs_2, ex_mem_alu_out, ex_mem_rd_num, ex_mem_func_3} !== '0) begin failures++; $display("FAIL reset_ex_mem_fields got alu=%h rs2=%h exp=0", ex_mem_alu_out, ex_mem_rs_2); end
    tick();
    checks++; if (if_id_inst !== 32'h13) begin failures++; $display("FAIL reset_held_edge got=%h exp=13", if_id_inst); end
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask
  task automatic test_pass_through;
    drive_all();
    tick();
    checks++; if (if_id_pc !== 32'h4 || if_id_inst !== 32'h0050_0093) begin failures++; $display("FAIL pass_if_id got pc=%h inst=%h exp pc=4 inst=00500093", if_id_pc, if_id_inst); end
    checks++; if (id_ex_pc !== 32'h100 || id_ex_rs_1 !== 32'h1111_1111 || id_ex_rs_2 !== 32'h2222_2222) begin failures++; $display("FAIL pass_id_ex_data got pc=%h rs1=%h rs2=%h", id_ex_pc, id_ex_rs_1, id_ex_rs_2); end
    checks++; if (id_ex_rd_num !== 5'd7 || id_ex_opcode !== 7'h33 || id_ex_func_7 !== 7'h20 || id_ex_func_3 !== 3'h5) begin failures++; $display("FAIL pass_id_ex_ctl got rd=%h op=%h f7=%h f3=%h", id_ex_rd_num, id_ex_opcode, id_ex_func_7, id_ex_func_3); end
    checks++; if (id_ex_imm_12_i !== 12'h123 || id_ex_imm_12_b !== 12'h456 || id_ex_imm_12_s !== 12'h789) begin failures++; $display("FAIL pass_id_ex_imm12 got i=%h b=%h s=%h", id_ex_imm_12_i, id_ex_imm_12_b, id_ex_imm_12_s); end
    checks++; if (id_ex_imm_20 !== 20'hABCDE || id_ex_imm_20_i !== 20'h12345) begin failures++; $display("FAIL pass_id_ex_imm20 got u=%h j=%h exp u=abcde j=12345", id_ex_imm_20, id_ex_imm_20_i); end
    checks++; if (ex_mem_alu_out !== 32'hDEAD_BEEF || ex_mem_rs_2 !== 32'hCAFE_F00D) begin failures++; $display("FAIL pass_ex_mem_data got alu=%h rs2=%h", ex_mem_alu_out, ex_mem_rs_2); end
    checks++; if (ex_mem_rd_num !== 5'd9 || ex_mem_opcode !== 7'h23 || ex_mem_func_3 !== 3'h2 || ex_mem_op_type !== 1'b1) begin failures++; $display("FAIL pass_ex_mem_ctl got rd=%h op=%h f3=%h type=%b", ex_mem_rd_num, ex_mem_opcode, ex_mem_func_3, ex_mem_op_type); end
    i_if_id_inst = 32'hFFFF_FFFF; i_ex_mem_alu_out = 32'h0;
    #2;
    checks++; if (if_id_inst !== 32'h0050_0093 || ex_mem_alu_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pass_no_comb_path got inst=%h alu=%h", if_id_inst, ex_mem_alu_out); end
  endtask
  task automatic test_flush_if_id;
    i_flush_if_id = 1'b1; i_if_id_inst = 32'h00A0_0113; i_if_id_pc = 32'h8;
    tick();
    checks++; if (if_id_inst !== 32'h13 || if_id_pc !== 32'h8) begin failures++; $display("FAIL flush_if_id got inst=%h pc=%h exp inst=13 pc=8", if_id_inst, if_id_pc); end
    i_flush_if_id = 1'b0;
    tick();
    checks++; if (if_id_inst !== 32'h00A0_0113) begin failures++; $display("FAIL flush_if_id_release got=%h exp=00a00113", if_id_inst); end
  endtask
  task automatic test_flush_id_ex;
    i_flush_id_ex = 1'b1; i_id_ex_rd_num = 5'd5; i_id_ex_opcode = 7'h33; i_ex_mem_alu_out = 32'h1234_5678;
    tick();
    checks++; if (id_ex_rd_num !== 5'd0 || id_ex_opcode !== 7'h13) begin failures++; $display("FAIL flush_id_ex got rd=%h op=%h exp rd=0 op=13", id_ex_rd_num, id_ex_opcode); end
    checks++; if (id_ex_rs_1 !== 32'h0 || id_ex_imm_20 !== 20'h0 || id_ex_pc !== 32'h0) begin failures++; $display("FAIL flush_id_ex_fields got rs1=%h imm20=%h pc=%h exp=0", id_ex_rs_1, id_ex_imm_20, id_ex_pc); end
    checks++; if (ex_mem_alu_out !== 32'h1234_5678) begin failures++; $display("FAIL flush_id_ex_mem_loads got=%h exp=12345678", ex_mem_alu_out); end
    i_flush_if_id = 1'b1; i_if_id_inst = 32'h0030_0193;
    tick();
    checks++; if (if_id_inst !== 32'h13 || id_ex_opcode !== 7'h13) begin failures++; $display("FAIL flush_both got inst=%h op=%h exp inst=13 op=13", if_id_inst, id_ex_opcode); end
    i_flush_if_id = 1'b0; i_flush_id_ex = 1'b0;
    tick();
    checks++; if (id_ex_rd_num !== 5'd5 || id_ex_opcode !== 7'h33) begin failures++; $display("FAIL flush_id_ex_release got rd=%h op=%h", id_ex_rd_num, id_ex_opcode); end
  endtask
`ifdef PIPE_STALL_EN
  task automatic test_stall;
    i_if_id_inst = 32'h0050_0093; i_if_id_pc = 32'h4;
    tick();
    i_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_if_id_inst = 32'h0070_0213 + k; i_if_id_pc = 32'h20 + k; i_ex_mem_alu_out = 32'hA0 + k;
      tick();
      checks++; if (if_id_inst !== 32'h0050_0093 || if_id_pc !== 32'h4) begin failures++; $display("FAIL stall_hold_%0d got inst=%h pc=%h exp inst=00500093 pc=4", k, if_id_inst, if_id_pc); end
      checks++; if (id_ex_opcode !== 7'h13 || id_ex_rd_num !== 5'd0) begin failures++; $display("FAIL stall_bubble_%0d got op=%h rd=%h", k, id_ex_opcode, id_ex_rd_num); end
      checks++; if (ex_mem_alu_out !== 32'hA0 + k) begin failures++; $display("FAIL stall_ex_mem_%0d got=%h exp=%h", k, ex_mem_alu_out, 32'hA0 + k); end
    end
    i_flush_if_id = 1'b1; i_if_id_pc = 32'h40;
    tick();
    checks++; if (if_id_inst !== 32'h13 || if_id_pc !== 32'h40) begin failures++; $display("FAIL stall_flush got inst=%h pc=%h exp inst=13 pc=40", if_id_inst, if_id_pc); end
    i_flush_if_id = 1'b0; i_stall = 1'b0;
  endtask
`endif
  task automatic test_back_to_back;
    logic [31:0] inst_k;
    for (int n = 1; n <= 10; n++) begin
      i_if_id_pc = (n <= 8) ? 32'h1000 + 32'(4 * (n - 1)) : 32'h0;
      i_if_id_inst = (n <= 8) ? 32'h0010_0093 + 32'((n - 1) << 20) : 32'h13;
      i_id_ex_pc = if_id_pc; i_id_ex_rs_1 = if_id_inst;
      i_ex_mem_alu_out = id_ex_pc; i_ex_mem_rs_2 = id_ex_rs_1;
      tick();
      if (n >= 3) begin
        inst_k = 32'h0010_0093 + 32'((n - 3) << 20);
        checks++; if (ex_mem_alu_out !== 32'h1000 + 32'(4 * (n - 3)) || ex_mem_rs_2 !== inst_k) begin failures++; $display("FAIL b2b_%0d got pc=%h inst=%h exp pc=%h inst=%h", n - 3, ex_mem_alu_out, ex_mem_rs_2, 32'h1000 + 32'(4 * (n - 3)), inst_k); end
      end
    end
  endtask
  initial begin
    i_rst = 1'b1; i_flush_if_id = 1'b0; i_flush_id_ex = 1'b0;
`ifdef PIPE_STALL_EN
    i_stall = 1'b0;
`endif
    test_reset();
    test_pass_through();
    test_flush_if_id();
    test_flush_id_ex();
`ifdef PIPE_STALL_EN
    test_stall();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_reg_bank.md
Name: pipe_reg_bank

Overview:
- Grouped front-end pipeline registers of the 5-stage RV32I core: IF/ID, ID/EX and EX/MEM, in one clocked block.
- Captures fetch, decode and execute outputs on each rising edge and presents them to the next stage.
- Supports per-stage flush (bubble insertion) and load-use stall.
- MEM/WB is out of scope.

Parameters:
- NOP_INST, 32'h00000013, instruction word loaded on reset or flush (addi x0,x0,0).
- NOP_OPCODE, 7'h13, opcode field used for bubbles.

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_flush_if_id  in  1  replace IF/ID contents with NOP next edge (branch taken in decode).
- i_flush_id_ex  in  1  load bubble into ID/EX next edge.
- i_if_id_pc, i_if_id_inst  in  32 each  fetch PC and instruction.
- if_id_pc, if_id_inst  out  32 each  registered PC and instruction to decode.
- i_id_ex_pc, i_id_ex_rs_1, i_id_ex_rs_2  in  32 each  decode PC and register operand values.
- i_id_ex_rd_num  in  5  destination register number.
- i_id_ex_opcode, i_id_ex_func_7  in  7 each  opcode and funct7 fields.
- i_id_ex_func_3  in  3  funct3 field.
- i_id_ex_imm_12_i, i_id_ex_imm_12_b, i_id_ex_imm_12_s  in  12 each  I/B/S immediates.
- i_id_ex_imm_20, i_id_ex_imm_20_i  in  20 each  U and J immediates.
- id_ex_pc, id_ex_rs_1, id_ex_rs_2, id_ex_rd_num, id_ex_opcode, id_ex_func_7, id_ex_func_3, id_ex_imm_12_i, id_ex_imm_12_b, id_ex_imm_12_s, id_ex_imm_20, id_ex_imm_20_i  out  same widths as the i_id_ex_* inputs  registered copies.
- i_ex_mem_rs_2, i_ex_mem_alu_out  in  32 each  store data and ALU result.
- i_ex_mem_rd_num  in  5  destination register number.
- i_ex_mem_opcode  in  7  opcode.
- i_ex_mem_func_3  in  3  funct3 (access size).
- i_ex_mem_op_type  in  1  memory op: 1=write, 0=read/none.
- ex_mem_rs_2, ex_mem_alu_out, ex_mem_rd_num, ex_mem_opcode, ex_mem_func_3, ex_mem_op_type  out  same widths as inputs  registered copies.

Behaviour:
- Single clock domain. i_clk and i_rst names fixed; reset is asynchronous, active-low.
- All outputs come straight from flops; no combinational input-to-output path.
- Latency is exactly 1 cycle per stage register.
- Reset (i_rst=0, immediate, independent of clock):
  - if_id_inst=NOP_INST; if_id_pc=0.
  - ID/EX: opcode=NOP_OPCODE; all other fields 0.
  - EX/MEM: opcode=NOP_OPCODE, op_type=0; all other fields 0.
- Release of reset takes effect at the first rising edge with i_rst=1.
- Normal edge (no flush/stall): each register loads its i_* inputs.
- Bubble means: opcode=NOP_OPCODE, rd_num=0, op_type=0 where present; all other fields 0.
- i_flush_if_id=1: if_id_inst<=NOP_INST and if_id_pc<=i_if_id_pc.
- i_flush_id_ex=1: ID/EX loads bubble.
- EX/MEM has no flush; it always loads when not in reset.
- Flush and data inputs sampled only at the rising edge; pulses between edges are ignored.
- Flushes are independent; both may assert in the same cycle.
- No sign extension or width conversion; every field is stored bit-exact.

Optional Feature:
- Macro PIPE_STALL_EN.
- Defined: adds input i_stall (1 bit).
  - i_stall=1 at an edge: IF/ID holds its value; ID/EX loads bubble (load-use stall); EX/MEM loads normally.
  - i_flush_if_id overrides the IF/ID hold; i_flush_id_ex has the same effect as stall on ID/EX.
- Undefined: no i_stall port; IF/ID and ID/EX load every edge unless flushed.

Test Plan:
- Reset: drive i_rst=0 mid-cycle with non-zero inputs -> outputs change without a clock edge: if_id_inst=32'h13, id_ex_opcode=7'h13, ex_mem_op_type=0, all other fields 0.
- Pass-through: i_if_id_pc=32'h4, i_if_id_inst=32'h00500093 -> after 1 edge if_id_pc=4, if_id_inst=32'h00500093. Feed ID/EX and EX/MEM with distinct patterns (imm_20=20'hABCDE, alu_out=32'hDEADBEEF, op_type=1) -> each appears unchanged after 1 edge.
- Flush IF/ID: i_flush_if_id=1, i_if_id_inst=32'h00A00113, i_if_id_pc=32'h8 -> if_id_inst=32'h13, if_id_pc=8. Next edge with flush=0 loads normally.
- Flush ID/EX: i_flush_id_ex=1, i_id_ex_rd_num=5, i_id_ex_opcode=7'h33 -> id_ex_rd_num=0, id_ex_opcode=7'h13; EX/MEM still loads its inputs the same edge.
- Stall (PIPE_STALL_EN): hold i_stall=1 for 2 edges while i_if_id_inst changes -> if_id_inst keeps its pre-stall value and ID/EX is a bubble both cycles. Stall+flush_if_id on the same edge -> if_id_inst=32'h13.
- Back-to-back: stream 8 sequential instructions with no flush or stall -> each reaches EX/MEM outputs in order, 3 cycles after entering the IF/ID inputs, with no gaps.
